// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone slave arbiter.
// The optional watchdog is enabled by defining WB_ARB_TIMEOUT_EN.
package wb_arb_pkg;

  // Arbiter states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  // Plain constants for the state register encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  // Watchdog counter width.
  localparam int TO_CNT_W = 16;

  // Width of an index into n masters; at least one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: finds the first requester strictly
// after 'last', wrapping circularly, using a double-width masked search.
import wb_arb_pkg::*;

module wb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] index
);

  logic [N-1:0]   above_mask;
  logic [2*N-1:0] dbl_req;

  // Mask keeps only requesters with an index above the last grant.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign above_mask[gi] = (IW'(gi) > last);
    end
  endgenerate

  // Lower half holds the masked requests, upper half the wrapped ones;
  // the lowest set bit of the combined vector is the round-robin winner.
  always_comb begin
    dbl_req = {req, req & above_mask};
    valid   = |req;
    index   = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl_req[i]) index = IW'(i % N);
    end
  end

endmodule

// File: rtl/wb_slave_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave among
// NUM_MASTERS masters. A grant is held for a whole cyc; one idle cycle
// always separates two grants. Define WB_ARB_TIMEOUT_EN to add a
// watchdog that errors and aborts a cycle the slave never answers.
import wb_arb_pkg::*;

module wb_slave_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADR_W          = 30,
  parameter int DAT_W          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_MASTERS-1:0]              m_cyc,
  input  logic [NUM_MASTERS-1:0]              m_stb,
  input  logic [NUM_MASTERS-1:0]              m_we,
  input  logic [NUM_MASTERS*ADR_W-1:0]        m_adr,
  input  logic [NUM_MASTERS*DAT_W-1:0]        m_dat_w,
  input  logic [NUM_MASTERS*(DAT_W/8)-1:0]    m_sel,
  output logic [NUM_MASTERS-1:0]              m_ack,
  output logic [NUM_MASTERS-1:0]              m_err,
  output logic [NUM_MASTERS-1:0]              m_stall,
  output logic [DAT_W-1:0]                    m_dat_r,
  output logic                                s_cyc,
  output logic                                s_stb,
  output logic                                s_we,
  output logic [ADR_W-1:0]                    s_adr,
  output logic [DAT_W-1:0]                    s_dat_w,
  output logic [DAT_W/8-1:0]                  s_sel,
  input  logic                                s_ack,
  input  logic                                s_err,
  input  logic                                s_stall,
  input  logic [DAT_W-1:0]                    s_dat_r,
  output logic [NUM_MASTERS-1:0]              grant
);

  localparam int IW    = idx_w(NUM_MASTERS);
  localparam int SEL_W = DAT_W / 8;
  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]             state_reg, state_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  // last_reg doubles as the granted index: it is only updated when a
  // grant is issued, so it always names the current owner in GRANT/ABORT.
  logic [IW-1:0]          last_reg, last_next;

  logic                   pick_valid;
  logic [IW-1:0]          pick_idx;
  logic                   to_hit;
  logic                   cyc_g;

  logic [ADR_W-1:0]       adr_arr [NUM_MASTERS];
  logic [DAT_W-1:0]       dat_arr [NUM_MASTERS];
  logic [SEL_W-1:0]       sel_arr [NUM_MASTERS];

  // Unpack the per-master buses into arrays for indexed muxing.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign adr_arr[gi] = m_adr[gi*ADR_W +: ADR_W];
      assign dat_arr[gi] = m_dat_w[gi*DAT_W +: DAT_W];
      assign sel_arr[gi] = m_sel[gi*SEL_W +: SEL_W];
    end
  endgenerate

  wb_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req   (m_cyc),
    .last  (last_reg),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign cyc_g   = m_cyc[last_reg];
  assign grant   = grant_reg;
  assign m_dat_r = s_dat_r;

`ifdef WB_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] wdog_reg, wdog_next;
  logic                wait_cycle;

  // A wait cycle is an open slave cycle in GRANT with no response.
  assign wait_cycle = (state_reg == ST_GRANT) && cyc_g && !s_ack && !s_err;
  assign to_hit     = wait_cycle && (wdog_reg == TO_LIMIT);

  // Watchdog counts consecutive wait cycles; any response or state change clears it.
  always_comb begin
    wdog_next = '0;
    if (wait_cycle && !to_hit) wdog_next = wdog_reg + 1'b1;
  end

  // Watchdog register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_reg <= '0;
    else        wdog_reg <= wdog_next;
  end
`else
  logic unused_to;

  assign to_hit    = 1'b0;
  assign unused_to = ^TO_LIMIT;
`endif

  // Next-state logic: arbitrate in IDLE, hold while the owner keeps cyc.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next           = ST_GRANT;
          grant_next           = '0;
          grant_next[pick_idx] = 1'b1;
          last_next            = pick_idx;
        end
      end
      ST_GRANT: begin
        if (!cyc_g) begin
          state_next = ST_IDLE;
          grant_next = '0;
        end else if (to_hit) begin
          state_next = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (!cyc_g) begin
          state_next = ST_IDLE;
          grant_next = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      last_reg  <= IW'(NUM_MASTERS - 1);
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
    end
  end

  // Bus routing: the owner talks to the slave in GRANT, everyone else stalls.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = m_we[last_reg];
    s_adr   = adr_arr[last_reg];
    s_dat_w = dat_arr[last_reg];
    s_sel   = sel_arr[last_reg];
    m_ack   = '0;
    m_err   = '0;
    m_stall = '1;
    if (state_reg == ST_GRANT) begin
      s_cyc             = cyc_g;
      s_stb             = m_stb[last_reg] & cyc_g;
      m_stall[last_reg] = s_stall;
      m_ack[last_reg]   = s_ack;
      m_err[last_reg]   = s_err | to_hit;
    end
  end

endmodule

// File: tb/tb_wb_slave_arbiter.sv
// Directed self-checking bench for wb_slave_arbiter with two masters.
// With WB_ARB_TIMEOUT_EN defined, the watchdog scenario is also run.
`timescale 1ns/1ps
module tb_wb_slave_arbiter;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [59:0] m_adr;
  logic [63:0] m_dat_w;
  logic [7:0]  m_sel;
  logic [1:0]  m_ack, m_err, m_stall;
  logic [31:0] m_dat_r;
  logic        s_cyc, s_stb, s_we;
  logic [29:0] s_adr;
  logic [31:0] s_dat_w;
  logic [3:0]  s_sel;
  logic        s_ack, s_err, s_stall;
  logic [31:0] s_dat_r;
  logic [1:0]  grant;

  int tests_run    = 0;
  int tests_failed = 0;

  wb_slave_arbiter #(
    .NUM_MASTERS    (2),
    .ADR_W          (30),
    .DAT_W          (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_cyc   (m_cyc),
    .m_stb   (m_stb),
    .m_we    (m_we),
    .m_adr   (m_adr),
    .m_dat_w (m_dat_w),
    .m_sel   (m_sel),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .m_stall (m_stall),
    .m_dat_r (m_dat_r),
    .s_cyc   (s_cyc),
    .s_stb   (s_stb),
    .s_we    (s_we),
    .s_adr   (s_adr),
    .s_dat_w (s_dat_w),
    .s_sel   (s_sel),
    .s_ack   (s_ack),
    .s_err   (s_err),
    .s_stall (s_stall),
    .s_dat_r (s_dat_r),
    .grant   (grant)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat_w = '0; m_sel = '0;
    s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0; s_dat_r = '0;
    @(negedge clk);
    tests_run++;
    if ({grant, s_cyc, s_stb, m_stall, m_ack, m_err} !== {2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00}) begin
      tests_failed++;
      $display("FAIL reset_outputs: grant=%b s_cyc=%b s_stb=%b m_stall=%b m_ack=%b m_err=%b, want 00 0 0 11 00 00",
               grant, s_cyc, s_stb, m_stall, m_ack, m_err);
    end
    tick;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests_run++;
      if ({grant, s_cyc, m_stall} !== {2'b00, 1'b0, 2'b11}) begin
        tests_failed++;
        $display("FAIL idle_cycle%0d: grant=%b s_cyc=%b m_stall=%b, want 00 0 11", c, grant, s_cyc, m_stall);
      end
    end
    $display("[TB] reset: 10 idle cycles observed");
  endtask

  task automatic test_two_masters;
    tick;
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b01;
    m_adr[0 +: 30] = 30'h10; m_dat_w[0 +: 32] = 32'h1234; m_sel[0 +: 4] = 4'hF;
    m_adr[30 +: 30] = 30'h20;
    @(negedge clk);
    tests_run++;
    if ({grant, s_cyc} !== 3'b000) begin
      tests_failed++;
      $display("FAIL arb_latency: grant=%b s_cyc=%b, want 00 0", grant, s_cyc);
    end
    tick;
    s_ack = 1'b1; s_dat_r = 32'h0;
    @(negedge clk);
    tests_run++;
    if ({grant, s_cyc, s_stb, s_we, m_stall, m_ack} !== {2'b01, 3'b111, 2'b10, 2'b01}) begin
      tests_failed++;
      $display("FAIL m0_grant: grant=%b cyc/stb/we=%b%b%b m_stall=%b m_ack=%b, want 01 111 10 01",
               grant, s_cyc, s_stb, s_we, m_stall, m_ack);
    end
    tests_run++;
    if ({s_adr, s_dat_w, s_sel} !== {30'h10, 32'h1234, 4'hF}) begin
      tests_failed++;
      $display("FAIL m0_mux: adr=%h dat=%h sel=%h, want 10 1234 f", s_adr, s_dat_w, s_sel);
    end
    $display("[TB] m0 write adr=%h dat=%h ack=%b", s_adr, s_dat_w, m_ack[0]);
    tick;
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({grant, s_cyc} !== {2'b01, 1'b0}) begin
      tests_failed++;
      $display("FAIL m0_release: grant=%b s_cyc=%b, want 01 0", grant, s_cyc);
    end
    tick;
    @(negedge clk);
    tests_run++;
    if ({grant, m_stall, s_cyc} !== {2'b00, 2'b11, 1'b0}) begin
      tests_failed++;
      $display("FAIL idle_gap: grant=%b m_stall=%b s_cyc=%b, want 00 11 0", grant, m_stall, s_cyc);
    end
    tick;
    s_ack = 1'b1; s_dat_r = 32'h77;
    @(negedge clk);
    tests_run++;
    if ({grant, s_we, m_stall, m_ack, s_adr} !== {2'b10, 1'b0, 2'b01, 2'b10, 30'h20}) begin
      tests_failed++;
      $display("FAIL m1_grant: grant=%b we=%b m_stall=%b m_ack=%b adr=%h, want 10 0 01 10 20",
               grant, s_we, m_stall, m_ack, s_adr);
    end
    tests_run++;
    if (m_dat_r !== 32'h77) begin
      tests_failed++;
      $display("FAIL m1_rdata: m_dat_r=%h, want 77", m_dat_r);
    end
    $display("[TB] m1 read adr=%h dat=%h", s_adr, m_dat_r);
    tick;
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    tick;
  endtask

  task automatic test_burst;
    int acks;
    acks = 0;
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b00;
    m_adr[30 +: 30] = 30'h40;
    tick;
    for (int k = 0; k < 5; k++) begin
      m_stb[1] = (k < 4);
      m_adr[30 +: 30] = 30'h40 + 30'(k);
      s_ack = (k >= 1);
      s_dat_r = 32'hA0 + 32'(k) - 32'h1;
      if (k == 2) begin
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0 +: 30] = 30'h55;
      end
      @(negedge clk);
      tests_run++;
      if ({grant, m_stall[0], m_ack[0], m_ack[1]} !== {2'b10, 1'b1, 1'b0, (k >= 1)}) begin
        tests_failed++;
        $display("FAIL burst_beat%0d: grant=%b stall0=%b ack0=%b ack1=%b, want 10 1 0 %0d",
                 k, grant, m_stall[0], m_ack[0], m_ack[1], (k >= 1));
      end
      if (k >= 1) begin
        tests_run++;
        if (m_dat_r !== 32'hA0 + 32'(k) - 32'h1) begin
          tests_failed++;
          $display("FAIL burst_data%0d: m_dat_r=%h, want %h", k, m_dat_r, 32'hA0 + 32'(k) - 32'h1);
        end
        $display("[TB] m1 burst ack dat=%h", m_dat_r);
      end
      if (m_ack[1] === 1'b1) acks++;
      tick;
    end
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tests_run++;
    if (acks !== 4) begin
      tests_failed++;
      $display("FAIL burst_ack_count: got %0d, want 4", acks);
    end
    tick;
    @(negedge clk);
    tests_run++;
    if ({grant, m_stall} !== {2'b00, 2'b11}) begin
      tests_failed++;
      $display("FAIL burst_gap: grant=%b m_stall=%b, want 00 11", grant, m_stall);
    end
    tick;
    @(negedge clk);
    tests_run++;
    if ({grant, s_adr} !== {2'b01, 30'h55}) begin
      tests_failed++;
      $display("FAIL burst_m0_after: grant=%b adr=%h, want 01 55", grant, s_adr);
    end
    m_cyc = '0; m_stb = '0;
    tick;
    tick;
  endtask

  task automatic test_slave_stall;
    int acks;
    acks = 0;
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
    m_adr[0 +: 30] = 30'h1; m_dat_w[0 +: 32] = 32'h5;
    tick;
    for (int k = 0; k < 3; k++) begin
      s_stall = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({grant, m_stall, s_stb, s_adr, s_dat_w, m_ack} !== {2'b01, 2'b11, 1'b1, 30'h1, 32'h5, 2'b00}) begin
        tests_failed++;
        $display("FAIL stall_cycle%0d: grant=%b m_stall=%b stb=%b adr=%h dat=%h ack=%b, want 01 11 1 1 5 00",
                 k, grant, m_stall, s_stb, s_adr, s_dat_w, m_ack);
      end
      tick;
    end
    s_stall = 1'b0;
    @(negedge clk);
    tests_run++;
    if (m_stall !== 2'b10) begin
      tests_failed++;
      $display("FAIL stall_release: m_stall=%b, want 10", m_stall);
    end
    tick;
    m_stb = '0; s_ack = 1'b1;
    @(negedge clk);
    if (m_ack === 2'b01) acks++;
    tick;
    s_ack = 1'b0;
    @(negedge clk);
    if (m_ack !== 2'b00) acks++;
    tests_run++;
    if (acks !== 1) begin
      tests_failed++;
      $display("FAIL stall_single_ack: acks=%0d, want 1", acks);
    end
    $display("[TB] m0 stalled write adr=1 dat=5 acks=%0d", acks);
    m_cyc = '0;
    tick;
    tick;
  endtask

  task automatic test_async_reset;
    m_cyc = 2'b11; m_stb = 2'b00; m_we = 2'b00;
    tick;
    @(negedge clk);
    tests_run++;
    if ({grant, s_cyc} !== {2'b10, 1'b1}) begin
      tests_failed++;
      $display("FAIL pre_reset_grant: grant=%b s_cyc=%b, want 10 1", grant, s_cyc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({grant, s_cyc, m_stall} !== {2'b00, 1'b0, 2'b11}) begin
      tests_failed++;
      $display("FAIL async_reset: grant=%b s_cyc=%b m_stall=%b, want 00 0 11", grant, s_cyc, m_stall);
    end
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (grant !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_release_idle: grant=%b, want 00", grant);
    end
    tick;
    @(negedge clk);
    tests_run++;
    if (grant !== 2'b01) begin
      tests_failed++;
      $display("FAIL reset_first_grant: grant=%b, want 01", grant);
    end
    $display("[TB] async reset mid-transfer, regrant=%b", grant);
    m_cyc = '0;
    tick;
    tick;
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout;
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00;
    tick;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      tests_run++;
      if ({grant, s_cyc, m_err} !== {2'b10, 1'b1, (k == 8) ? 2'b10 : 2'b00}) begin
        tests_failed++;
        $display("FAIL wait_cycle%0d: grant=%b s_cyc=%b m_err=%b", k, grant, s_cyc, m_err);
      end
      tick;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests_run++;
      if ({grant, s_cyc, m_stall, m_err, m_ack} !== {2'b10, 1'b0, 2'b11, 2'b00, 2'b00}) begin
        tests_failed++;
        $display("FAIL abort%0d: grant=%b s_cyc=%b m_stall=%b m_err=%b m_ack=%b, want 10 0 11 00 00",
                 k, grant, s_cyc, m_stall, m_err, m_ack);
      end
      tick;
    end
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick;
    @(negedge clk);
    tests_run++;
    if (grant !== 2'b00) begin
      tests_failed++;
      $display("FAIL abort_exit: grant=%b, want 00", grant);
    end
    tick;
    @(negedge clk);
    tests_run++;
    if ({grant, s_cyc} !== {2'b01, 1'b1}) begin
      tests_failed++;
      $display("FAIL after_abort_grant: grant=%b s_cyc=%b, want 01 1", grant, s_cyc);
    end
    $display("[TB] timeout abort on m1, next grant=%b", grant);
    m_cyc = '0; m_stb = '0;
    tick;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset;
    test_two_masters;
    test_burst;
    test_slave_stall;
    test_async_reset;
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
